// File: rtl/onehot16_idx_fifo_pkg.sv
// Shared constants and the encoded-entry layout for the 16-way one-hot select path.
package onehot16_idx_fifo_pkg;

    localparam int ONEHOT_W     = 16;
    localparam int ONEHOT_IDX_W = 4;

    typedef struct packed {
        logic                    err;
        logic [ONEHOT_IDX_W-1:0] idx;
    } onehot_entry_t;

endpackage

// File: rtl/onehot16_idx_fifo_enc.sv
// One-hot to binary encoder. Malformed vectors (zero or multi-hot) raise err and
// report the lowest set bit, or 0 when no bit is set.
module onehot16_enc
    import onehot16_idx_fifo_pkg::*;
(
    input  logic [ONEHOT_W-1:0] i_oh,
    output onehot_entry_t       o_ent
);

    logic [ONEHOT_IDX_W-1:0] w_idx;
    logic                    w_zero;
    logic                    w_multi;

    always_comb begin
        w_idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (i_oh[i]) begin
                w_idx = ONEHOT_IDX_W'(i);
            end
        end
    end

    assign w_zero  = (i_oh == '0);
    assign w_multi = ((i_oh & (i_oh - 1'b1)) != '0);

    assign o_ent.idx = w_idx;
    assign o_ent.err = w_zero | w_multi;

endmodule

// File: rtl/onehot16_idx_fifo.sv
// Encodes accepted one-hot grant vectors and buffers {err, idx} in a small FIFO
// that drains through a valid/ready handshake; keeps a sticky malformed-input flag.
module onehot16_idx_fifo
    import onehot16_idx_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_vld,
    output logic                    o_in_rdy,
    input  logic [ONEHOT_W-1:0]     i_in_oh,
    output logic                    o_out_vld,
    input  logic                    i_out_rdy,
    output logic [ONEHOT_IDX_W-1:0] o_out_idx,
    output logic                    o_out_err,
    output logic [CNT_W-1:0]        o_occ,
    output logic                    o_err_sticky,
    input  logic                    i_err_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    onehot_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic             r_err_sticky;

    onehot_entry_t    w_enc;
    onehot_entry_t    w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_in_rdy;
    logic             w_out_vld;

    onehot16_enc u_enc (
        .i_oh  (i_in_oh),
        .o_ent (w_enc)
    );

    // Full is judged on occupancy alone, so a same-cycle pop never frees a slot.
    assign w_in_rdy  = !i_rst && (r_occ != CNT_W'(DEPTH));
    assign w_out_vld = (r_occ != '0);
    assign w_push    = i_in_vld && w_in_rdy;
    assign w_pop     = w_out_vld && i_out_rdy;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_enc;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_push && w_enc.err) begin
                r_err_sticky <= 1'b1;
            end else if (i_err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign o_in_rdy     = w_in_rdy;
    assign o_out_vld    = w_out_vld;
    assign o_out_idx    = w_out_vld ? w_head.idx : '0;
    assign o_out_err    = w_out_vld ? w_head.err : 1'b0;
    assign o_occ        = r_occ;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_onehot16_idx_fifo.sv
// Directed bench for onehot16_idx_fifo: inputs are driven and outputs sampled on
// the falling edge, expected values are hand-computed constants.
module tb_onehot16_idx_fifo;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_oh;
    logic        out_vld;
    logic        out_rdy;
    logic [3:0]  out_idx;
    logic        out_err;
    logic [2:0]  occ;
    logic        err_sticky;
    logic        err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    onehot16_idx_fifo #(.DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_vld     (in_vld),
        .o_in_rdy     (in_rdy),
        .i_in_oh      (in_oh),
        .o_out_vld    (out_vld),
        .i_out_rdy    (out_rdy),
        .o_out_idx    (out_idx),
        .o_out_err    (out_err),
        .o_occ        (occ),
        .o_err_sticky (err_sticky),
        .i_err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and return to the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] v);
        in_vld = 1'b1;
        in_oh  = v;
        cyc();
        in_vld = 1'b0;
        in_oh  = '0;
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] idx, input logic err);
        chk({tag, "_vld"}, 32'(out_vld), 32'd1);
        chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, "_err"}, 32'(out_err), 32'(err));
        out_rdy = 1'b1;
        cyc();
        out_rdy = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_oh   = '0;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        cyc();

        // 1: reset state and a single clean push
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        cyc();
        chk("t1_in_rdy", 32'(in_rdy), 32'd1);
        push(16'h0100);
        chk("t1_occ", 32'(occ), 32'd1);
        chk("t1_sticky", 32'(err_sticky), 32'd0);
        pop_chk("t1", 4'd8, 1'b0);
        chk("t1_occ_after", 32'(occ), 32'd0);

        // 2: malformed vectors and sticky error
        push(16'h0000);
        push(16'h0006);
        chk("t2_occ", 32'(occ), 32'd2);
        chk("t2_sticky", 32'(err_sticky), 32'd1);
        pop_chk("t2_zero", 4'd0, 1'b1);
        pop_chk("t2_multi", 4'd1, 1'b1);
        cyc();
        chk("t2_sticky_hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t2_sticky_clr", 32'(err_sticky), 32'd0);

        // 3: fill to full, refuse a 5th push even with a same-cycle pop
        push(16'h0008);
        push(16'h0020);
        push(16'h0400);
        push(16'h8000);
        chk("t3_occ_full", 32'(occ), 32'd4);
        chk("t3_in_rdy_full", 32'(in_rdy), 32'd0);
        in_vld = 1'b1;
        in_oh  = 16'h0080;
        cyc();
        chk("t3_refused_occ", 32'(occ), 32'd4);
        chk("t3_head", 32'(out_idx), 32'd3);
        out_rdy = 1'b1;
        cyc();
        out_rdy = 1'b0;
        in_vld  = 1'b0;
        chk("t3_pop_only_occ", 32'(occ), 32'd3);
        pop_chk("t3_d1", 4'd5, 1'b0);
        pop_chk("t3_d2", 4'd10, 1'b0);
        pop_chk("t3_d3", 4'd15, 1'b0);
        chk("t3_empty", 32'(occ), 32'd0);
        chk("t3_sticky", 32'(err_sticky), 32'd0);

        // 4: steady push+pop at half full, bits 0..11, pointers wrap
        push(16'h0001);
        push(16'h0002);
        for (int k = 2; k < 12; k++) begin
            chk($sformatf("t4_head%0d", k), 32'(out_idx), 32'(k - 2));
            in_vld  = 1'b1;
            in_oh   = 16'(1) << k;
            out_rdy = 1'b1;
            cyc();
            chk($sformatf("t4_occ%0d", k), 32'(occ), 32'd2);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        pop_chk("t4_d10", 4'd10, 1'b0);
        pop_chk("t4_d11", 4'd11, 1'b0);
        chk("t4_empty", 32'(out_vld), 32'd0);

        // 5: reset mid-stream discards entries
        push(16'h0010);
        push(16'h0020);
        push(16'h0040);
        chk("t5_occ", 32'(occ), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_in_rdy_rst", 32'(in_rdy), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_occ_after", 32'(occ), 32'd0);
        chk("t5_out_vld", 32'(out_vld), 32'd0);
        chk("t5_out_idx", 32'(out_idx), 32'd0);
        chk("t5_in_rdy", 32'(in_rdy), 32'd1);

        // 6: set wins over clear
        err_clr = 1'b1;
        push(16'h0003);
        err_clr = 1'b0;
        chk("t6_sticky", 32'(err_sticky), 32'd1);
        pop_chk("t6_entry", 4'd0, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t6_sticky_clr", 32'(err_sticky), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
